// File: rtl/contador_mod6_pkg.sv
//------------------------------------------------------------------------------
// Module      : contador_mod6_pkg
// Description : Shared timer constants, BCD digit type and load saturation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package contador_mod6_pkg;

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned MOD6_MAX = 5;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // Values above the wrap limit clamp to it so a bad BCD load stays legal.
    function automatic logic [2:0] sat_digit(input bcd_digit_t d, input logic [2:0] max);
        if (d > {1'b0, max})
            return max;
        return d[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_mod6.sv
//------------------------------------------------------------------------------
// Module      : contador_mod6
// Description : Loadable modulo-6 down counter, tens-of-seconds timer digit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module contador_mod6
    import contador_mod6_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MOD6_MAX
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic               loadn,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] data,
    output logic [DIGIT_W-1:0] tens,
    output logic               zero,
    output logic               tc
);

    localparam logic [2:0] C_MAX = MAX_COUNT[2:0];

    logic [2:0] r_count;
    logic [2:0] w_load;
    logic [2:0] w_next;

    assign w_load = sat_digit(data, C_MAX);

    // Zero wraps to the top; unreachable codes above the top also recover there.
    assign w_next = (r_count == 3'd0 || r_count > C_MAX) ? C_MAX : r_count - 3'd1;

    always_ff @(posedge clock or negedge clrn or negedge loadn) begin
        if (!clrn)
            r_count <= 3'd0;
        else if (!loadn)
            r_count <= w_load;
        else if (enable)
            r_count <= w_next;
    end

    assign tens = {1'b0, r_count};
    assign zero = (r_count == 3'd0);
    assign tc   = zero & enable;

endmodule

`default_nettype wire

// File: tb/tb_contador_mod6.sv
//------------------------------------------------------------------------------
// Module      : tb_contador_mod6
// Description : Directed self-checking bench for contador_mod6.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_contador_mod6;

    logic       clock;
    logic       clrn;
    logic       loadn;
    logic       enable;
    logic [3:0] data;
    logic [3:0] tens;
    logic       zero;
    logic       tc;

    int n_checks;
    int n_fail;

    contador_mod6 #(.MAX_COUNT(5)) dut (
        .clock  (clock),
        .clrn   (clrn),
        .loadn  (loadn),
        .enable (enable),
        .data   (data),
        .tens   (tens),
        .zero   (zero),
        .tc     (tc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0; loadn = 1'b1; enable = 1'b0; data = 4'd0;
        #2;
        n_checks++;
        if (tens !== 4'd0 || zero !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: tens=%0d zero=%b tc=%b, want tens=0 zero=1 tc=0", tens, zero, tc);
        end
        enable = 1'b1;
        #1;
        n_checks++;
        if (tc !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tc: tc=%b, want 1", tc);
        end
        edge_sample();
        n_checks++;
        if (tens !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold: tens=%0d while clrn low, want 0", tens);
        end
        @(negedge clock);
        enable = 1'b0;
        clrn   = 1'b1;
    endtask

    task automatic test_load();
        @(negedge clock);
        data  = 4'd4;
        loadn = 1'b0;
        #1;
        n_checks++;
        if (tens !== 4'd4 || zero !== 1'b0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL load: tens=%0d zero=%b tc=%b, want tens=4 zero=0 tc=0", tens, zero, tc);
        end
        #3;
        loadn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_sample();
            n_checks++;
            if (tens !== 4'd4) begin
                n_fail++;
                $display("FAIL load_hold[%0d]: tens=%0d, want 4", i, tens);
            end
        end
    endtask

    task automatic test_countdown();
        logic [3:0] exp_seq [7] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd5, 4'd4, 4'd3};
        logic       ez;
        @(negedge clock);
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge_sample();
            ez = (exp_seq[i] == 4'd0);
            n_checks++;
            if (tens !== exp_seq[i] || zero !== ez || tc !== ez) begin
                n_fail++;
                $display("FAIL countdown[%0d]: tens=%0d zero=%b tc=%b, want tens=%0d zero=%b tc=%b",
                         i, tens, zero, tc, exp_seq[i], ez, ez);
            end
        end
    endtask

    task automatic test_hold();
        edge_sample();
        n_checks++;
        if (tens !== 4'd2) begin
            n_fail++;
            $display("FAIL hold_pre: tens=%0d, want 2", tens);
        end
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            n_checks++;
            if (tens !== 4'd2 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: tens=%0d tc=%b, want tens=2 tc=0", i, tens, tc);
            end
        end
        @(negedge clock);
        enable = 1'b1;
        edge_sample();
        n_checks++;
        if (tens !== 4'd1) begin
            n_fail++;
            $display("FAIL hold_resume: tens=%0d, want 1", tens);
        end
    endtask

    task automatic test_clear();
        @(negedge clock);
        enable = 1'b0;
        data   = 4'd3;
        loadn  = 1'b0;
        #1;
        loadn = 1'b1;
        n_checks++;
        if (tens !== 4'd3) begin
            n_fail++;
            $display("FAIL clear_pre: tens=%0d, want 3", tens);
        end
        #1;
        clrn = 1'b0;
        #1;
        n_checks++;
        if (tens !== 4'd0 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_async: tens=%0d zero=%b, want tens=0 zero=1", tens, zero);
        end
        data  = 4'd4;
        loadn = 1'b0;
        #1;
        n_checks++;
        if (tens !== 4'd0) begin
            n_fail++;
            $display("FAIL clear_over_load: tens=%0d, want 0", tens);
        end
        loadn = 1'b1;
        #1;
        clrn = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        edge_sample();
        n_checks++;
        if (tens !== 4'd5) begin
            n_fail++;
            $display("FAIL clear_continue: tens=%0d, want 5", tens);
        end
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] din  [5] = '{4'd9, 4'd6, 4'd15, 4'd5, 4'd2};
        logic [3:0] dexp [5] = '{4'd5, 4'd5, 4'd5,  4'd5, 4'd2};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            data  = din[i];
            loadn = 1'b0;
            #1;
            n_checks++;
            if (tens !== dexp[i]) begin
                n_fail++;
                $display("FAIL sat_load[%0d]: data=%0d tens=%0d, want %0d", i, din[i], tens, dexp[i]);
            end
            loadn = 1'b1;
        end
        @(negedge clock);
        data  = 4'd0;
        loadn = 1'b0;
        #1;
        loadn = 1'b1;
        n_checks++;
        if (tens !== 4'd0 || zero !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL tc_gate_off: tens=%0d zero=%b tc=%b, want tens=0 zero=1 tc=0", tens, zero, tc);
        end
        enable = 1'b1;
        #1;
        n_checks++;
        if (tc !== 1'b1) begin
            n_fail++;
            $display("FAIL tc_gate_on: tc=%b, want 1", tc);
        end
        edge_sample();
        n_checks++;
        if (tens !== 4'd5 || tc !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL tc_wrap: tens=%0d zero=%b tc=%b, want tens=5 zero=0 tc=0", tens, zero, tc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load();
        test_countdown();
        test_hold();
        test_clear();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
